// File: rtl/atm_transaction_controller.sv
`default_nettype none
// ============================================================================
// atm_transaction_controller: single-account ATM session FSM (PIN, deposit,
// withdrawal, lockout) with registered status/command outputs.
// Revision: 1.0
// ============================================================================
module atm_transaction_controller #(
  parameter logic [15:0] PIN          = 16'h3987,
  parameter logic [63:0] BALANCE_INIT = 64'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tarjeta_recibida,
  input  logic        tipo_trans,
  input  logic        digito_stb,
  input  logic [3:0]  digito,
  input  logic        monto_stb,
  input  logic [31:0] monto,
  output logic        balance_actualizado,
  output logic        entregar_dinero,
  output logic        pin_incorrecto,
  output logic        advertencia,
  output logic        bloqueo,
  output logic        fondos_insuficientes
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PIN     = 2'd1,
    ST_TRANS   = 2'd2,
    ST_BLOCKED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] balance_q, balance_d;
  logic [1:0]  attempts_q, attempts_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] pin_sr_q, pin_sr_d;
  logic        upd_q, upd_d;
  logic        ent_q, ent_d;
  logic        pin_bad_q, pin_bad_d;
  logic        adv_q, adv_d;
  logic        blk_q, blk_d;
  logic        fondos_q, fondos_d;

  logic [15:0] pin_cand;
  logic [1:0]  attempts_inc;
  logic [63:0] monto_ext;

  assign pin_cand     = {pin_sr_q[11:0], digito};
  assign attempts_inc = attempts_q + 2'd1;
  assign monto_ext    = {32'd0, monto};

  always_comb begin
    state_d    = state_q;
    balance_d  = balance_q;
    attempts_d = attempts_q;
    count_d    = count_q;
    pin_sr_d   = pin_sr_q;
    adv_d      = adv_q;
    blk_d      = blk_q;
    upd_d      = 1'b0;
    ent_d      = 1'b0;
    pin_bad_d  = 1'b0;
    fondos_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tarjeta_recibida) begin
          state_d = ST_PIN;
          count_d = 2'd0;
        end
      end
      ST_PIN: begin
        if (digito_stb) begin
          pin_sr_d = pin_cand;
          if (count_q == 2'd3) begin
            // Fourth digit: judge the full code on this same edge.
            count_d = 2'd0;
            if (pin_cand == PIN) begin
              state_d    = ST_TRANS;
              attempts_d = 2'd0;
              adv_d      = 1'b0;
            end else begin
              pin_bad_d  = 1'b1;
              attempts_d = attempts_inc;
              if (attempts_inc == 2'd2) begin
                adv_d = 1'b1;
              end
              if (attempts_inc == 2'd3) begin
                state_d = ST_BLOCKED;
                blk_d   = 1'b1;
              end
            end
          end else begin
            count_d = count_q + 2'd1;
          end
        end
      end
      ST_TRANS: begin
        if (monto_stb) begin
          state_d = ST_IDLE;
          if (!tipo_trans) begin
            balance_d = balance_q + monto_ext;
            upd_d     = 1'b1;
          end else if (monto_ext <= balance_q) begin
            balance_d = balance_q - monto_ext;
            upd_d     = 1'b1;
            ent_d     = 1'b1;
          end else begin
            fondos_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BLOCKED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      balance_q  <= BALANCE_INIT;
      attempts_q <= 2'd0;
      count_q    <= 2'd0;
      pin_sr_q   <= 16'd0;
      upd_q      <= 1'b0;
      ent_q      <= 1'b0;
      pin_bad_q  <= 1'b0;
      adv_q      <= 1'b0;
      blk_q      <= 1'b0;
      fondos_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      balance_q  <= balance_d;
      attempts_q <= attempts_d;
      count_q    <= count_d;
      pin_sr_q   <= pin_sr_d;
      upd_q      <= upd_d;
      ent_q      <= ent_d;
      pin_bad_q  <= pin_bad_d;
      adv_q      <= adv_d;
      blk_q      <= blk_d;
      fondos_q   <= fondos_d;
    end
  end

  assign balance_actualizado  = upd_q;
  assign entregar_dinero      = ent_q;
  assign pin_incorrecto       = pin_bad_q;
  assign advertencia          = adv_q;
  assign bloqueo              = blk_q;
  assign fondos_insuficientes = fondos_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_transaction_controller.sv
`default_nettype none
// ============================================================================
// tb_atm_transaction_controller: directed sessions checked cycle-by-cycle
// against a transaction-level model, plus literal expectations.
// Revision: 1.0
// ============================================================================
module tb_atm_transaction_controller;

  localparam logic [15:0] C_PIN = 16'h3987;
  localparam logic [63:0] C_BAL = 64'd50000;
  localparam int M_IDLE = 0, M_PIN = 1, M_TRANS = 2, M_BLOCKED = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tarjeta_recibida = 1'b0;
  logic        tipo_trans = 1'b0;
  logic        digito_stb = 1'b0;
  logic [3:0]  digito = 4'd0;
  logic        monto_stb = 1'b0;
  logic [31:0] monto = 32'd0;
  logic        balance_actualizado, entregar_dinero, pin_incorrecto;
  logic        advertencia, bloqueo, fondos_insuficientes;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  atm_transaction_controller #(.PIN(C_PIN), .BALANCE_INIT(C_BAL)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tarjeta_recibida    (tarjeta_recibida),
    .tipo_trans          (tipo_trans),
    .digito_stb          (digito_stb),
    .digito              (digito),
    .monto_stb           (monto_stb),
    .monto               (monto),
    .balance_actualizado (balance_actualizado),
    .entregar_dinero     (entregar_dinero),
    .pin_incorrecto      (pin_incorrecto),
    .advertencia         (advertencia),
    .bloqueo             (bloqueo),
    .fondos_insuficientes(fondos_insuficientes)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: a list of digits typed so far, a balance and a retry count.
  int              mode = M_IDLE;
  longint unsigned m_bal = C_BAL;
  int              m_att = 0;
  int              digs[$];
  logic e_upd = 0, e_ent = 0, e_pin = 0, e_adv = 0, e_blk = 0, e_fon = 0;

  function automatic int pin_digit(input int i);
    logic [15:0] p;
    p = C_PIN;
    return int'(p[15-4*i -: 4]);
  endfunction

  always @(posedge clk) begin
    bit ok;
    e_upd = 0; e_ent = 0; e_pin = 0; e_fon = 0;
    if (rst) begin
      mode = M_IDLE; m_bal = C_BAL; m_att = 0; digs.delete();
      e_adv = 0; e_blk = 0;
    end else begin
      case (mode)
        M_IDLE: if (tarjeta_recibida) begin
          mode = M_PIN;
          digs.delete();
        end
        M_PIN: if (digito_stb) begin
          digs.push_back(int'(digito));
          if (digs.size() == 4) begin
            ok = 1;
            for (int i = 0; i < 4; i++) if (digs[i] != pin_digit(i)) ok = 0;
            digs.delete();
            if (ok) begin
              mode = M_TRANS; m_att = 0; e_adv = 0;
            end else begin
              m_att++;
              e_pin = 1;
              if (m_att == 2) e_adv = 1;
              if (m_att >= 3) begin mode = M_BLOCKED; e_blk = 1; end
            end
          end
        end
        M_TRANS: if (monto_stb) begin
          mode = M_IDLE;
          if (!tipo_trans) begin
            m_bal = m_bal + longint'(monto);
            e_upd = 1;
          end else if (longint'(monto) <= m_bal) begin
            m_bal = m_bal - longint'(monto);
            e_upd = 1; e_ent = 1;
          end else begin
            e_fon = 1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    chk("balance_actualizado", balance_actualizado, e_upd);
    chk("entregar_dinero", entregar_dinero, e_ent);
    chk("pin_incorrecto", pin_incorrecto, e_pin);
    chk("advertencia", advertencia, e_adv);
    chk("bloqueo", bloqueo, e_blk);
    chk("fondos_insuficientes", fondos_insuficientes, e_fon);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; tick(2); rst = 0;
  endtask

  task automatic card();
    tarjeta_recibida = 1; tick(1); tarjeta_recibida = 0;
  endtask

  task automatic digit(input logic [3:0] d);
    digito_stb = 1; digito = d; tick(1); digito_stb = 0;
  endtask

  task automatic pin(input logic [3:0] a, b, c, d);
    digit(a); digit(b); digit(c); digit(d);
  endtask

  task automatic trans(input logic t, input logic [31:0] m);
    monto_stb = 1; tipo_trans = t; monto = m; tick(1); monto_stb = 0;
  endtask

  initial begin
    tick(2); rst = 0;
    chk("reset_outputs", {balance_actualizado, entregar_dinero, pin_incorrecto,
                          advertencia, bloqueo, fondos_insuficientes}, 64'd0);

    // Deposit 1000 -> 51000, then probe the new balance at its boundary.
    card(); pin(3, 9, 8, 7); trans(0, 1000);
    chk("deposit_upd_ent", {balance_actualizado, entregar_dinero}, 64'b10);
    card(); pin(3, 9, 8, 7); trans(1, 51001);
    chk("over_51001", {fondos_insuficientes, entregar_dinero}, 64'b10);
    card(); pin(3, 9, 8, 7); trans(1, 51000);
    chk("exact_51000", {balance_actualizado, entregar_dinero}, 64'b11);

    do_reset();
    card(); pin(3, 9, 8, 7); trans(1, 20000);
    chk("wd_20000", {balance_actualizado, entregar_dinero}, 64'b11);
    card(); pin(3, 9, 8, 7); trans(1, 30000);
    chk("wd_30000", {balance_actualizado, entregar_dinero}, 64'b11);
    card(); pin(3, 9, 8, 7); trans(1, 1);
    chk("empty_wd_1", fondos_insuficientes, 64'd1);

    do_reset();
    card(); pin(3, 9, 8, 7); trans(1, 50001);
    chk("wd_50001", {fondos_insuficientes, entregar_dinero, balance_actualizado}, 64'b100);
    card(); pin(3, 9, 8, 7); trans(1, 50000);
    chk("wd_50000", {balance_actualizado, entregar_dinero}, 64'b11);

    // Two misses then the correct code clears the warning.
    do_reset();
    card(); pin(1, 2, 3, 4);
    chk("miss1", {pin_incorrecto, advertencia}, 64'b10);
    pin(1, 2, 3, 4);
    chk("miss2", {pin_incorrecto, advertencia}, 64'b11);
    pin(3, 9, 8, 7);
    chk("adv_cleared", advertencia, 64'd0);
    trans(0, 5);
    chk("trans_reached", balance_actualizado, 64'd1);

    // Lockout, then rst recovers.
    do_reset();
    card(); pin(1, 2, 3, 4); pin(5, 5, 5, 5); pin(0, 0, 0, 0);
    chk("blocked", {bloqueo, advertencia}, 64'b11);
    pin(3, 9, 8, 7); trans(1, 10); card(); tick(3);
    chk("blocked_quiet", {bloqueo, balance_actualizado, entregar_dinero,
                          pin_incorrecto, fondos_insuficientes}, 64'b10000);
    do_reset();
    chk("unblocked", {bloqueo, advertencia}, 64'b00);
    card(); pin(3, 9, 8, 7); trans(0, 7);
    chk("after_unblock", balance_actualizado, 64'd1);

    // rst mid-TRANS, gapped digits, out-of-range digit, concurrent strobes.
    card(); pin(3, 9, 8, 7);
    rst = 1; tick(1); rst = 0;
    trans(1, 100);
    chk("monto_ignored", {balance_actualizado, entregar_dinero, fondos_insuficientes}, 64'd0);
    card(); digit(3); tick(2); digit(9); tick(3); digit(8); digit(12);
    chk("digit_12", pin_incorrecto, 64'd1);
    digit(3); tick(1);
    monto_stb = 1; tipo_trans = 1; monto = 32'd5;
    digit(9);
    monto_stb = 0;
    tick(2); digit(8); tick(1); digit(7);
    chk("gapped_ok", {pin_incorrecto, advertencia}, 64'b00);
    trans(1, 50000);
    chk("balance_reinit", {balance_actualizado, entregar_dinero}, 64'b11);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
